// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light sequencer: state encoding,
// one-hot light codes and default interval durations.
package tl_pkg;

   typedef enum logic [2:0] {
      MAIN_GRN = 3'd0,
      MAIN_EXT = 3'd1,
      MAIN_YEL = 3'd2,
      WALK     = 3'd3,
      SIDE_GRN = 3'd4,
      SIDE_EXT = 3'd5,
      SIDE_YEL = 3'd6
   } tl_state_e;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   localparam int T_BASE_DEF  = 6;
   localparam int T_EXT_DEF   = 3;
   localparam int T_YEL_DEF   = 2;
   localparam int T_FLASH_DEF = 2;
   localparam int CNT_W_DEF   = 4;

   function automatic logic [2:0] main_lights(tl_state_e s);
      case (s)
         MAIN_GRN, MAIN_EXT: main_lights = LT_GRN;
         MAIN_YEL:           main_lights = LT_YEL;
         default:            main_lights = LT_RED;
      endcase
   endfunction

   function automatic logic [2:0] side_lights(tl_state_e s);
      case (s)
         SIDE_GRN, SIDE_EXT: side_lights = LT_GRN;
         SIDE_YEL:           side_lights = LT_YEL;
         default:            side_lights = LT_RED;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic light sequencer (slave) and its
// environment: timebase, walk latch, car sensor and all lamp outputs.
interface traffic_light_fsm_if;

   logic       tick;
   logic       walkRegister_status;
   logic       sensor;
   logic       walkRegister_reset;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk_lamp;
   logic [2:0] state_o;

   modport master (
      output tick, walkRegister_status, sensor,
      input  walkRegister_reset, main_light, side_light, walk_lamp, state_o
   );

   modport slave (
      input  tick, walkRegister_status, sensor,
      output walkRegister_reset, main_light, side_light, walk_lamp, state_o
   );

endinterface

// File: rtl/tl_interval_timer.sv
// Down-counting interval timer: loads a duration on state entry, decrements on
// tick and flags expiry on the tick that finds the count at 1.
module tl_interval_timer
   import tl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int RST_VAL = T_BASE_DEF
) (
   input  logic             clk,
   input  logic             sys_reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             expire,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire = tick && (cnt_q == CNT_W'(1));
   assign cnt_o  = cnt_q;

   // NOTE: combinational next-state uses blocking '=' with a default first so
   // no latch is inferred; the register below uses non-blocking '<=' only.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (tick)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch rather
   // than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!sys_reset_n)
         cnt_q <= CNT_W'(RST_VAL);
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side-street light sequencer with optional pedestrian walk phase.
// Define TL_WALK_FLASH_EN to flash the walk lamp during the last T_FLASH ticks.
module traffic_light_fsm
   import tl_pkg::*;
#(
   parameter int T_BASE  = T_BASE_DEF,
   parameter int T_EXT   = T_EXT_DEF,
   parameter int T_YEL   = T_YEL_DEF,
   parameter int T_FLASH = T_FLASH_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               sys_reset_n,
   traffic_light_fsm_if.slave bus
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   if (T_BASE < 1 || T_BASE > CNT_MAX || T_EXT < 1 || T_EXT > CNT_MAX ||
       T_YEL < 1 || T_YEL > CNT_MAX || T_FLASH < 1 || T_FLASH > CNT_MAX) begin : g_bad_param
      $error("traffic_light_fsm: duration parameter outside 1..2^CNT_W-1");
   end

   tl_state_e        state_q, nxt;
   logic [2:0]       main_q, side_q;
   logic             walk_rst_q;
   logic             expire;
   logic [CNT_W-1:0] cnt;

   function automatic logic [CNT_W-1:0] dur_of(tl_state_e s);
      case (s)
         MAIN_EXT, SIDE_EXT, WALK: dur_of = CNT_W'(T_EXT);
         MAIN_YEL, SIDE_YEL:       dur_of = CNT_W'(T_YEL);
         default:                  dur_of = CNT_W'(T_BASE);
      endcase
   endfunction

   // Inputs only matter in the expiry cycle; the successor is chosen here.
   always_comb begin
      nxt = state_q;
      case (state_q)
         MAIN_GRN: nxt = bus.sensor ? MAIN_EXT : MAIN_YEL;
         MAIN_EXT: nxt = MAIN_YEL;
         MAIN_YEL: nxt = bus.walkRegister_status ? WALK : SIDE_GRN;
         WALK:     nxt = SIDE_GRN;
         SIDE_GRN: nxt = bus.sensor ? SIDE_EXT : SIDE_YEL;
         SIDE_EXT: nxt = SIDE_YEL;
         SIDE_YEL: nxt = MAIN_GRN;
         default:  nxt = MAIN_GRN;
      endcase
   end

   tl_interval_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (T_BASE)
   ) u_timer (
      .clk         (clk),
      .sys_reset_n (sys_reset_n),
      .load        (expire),
      .load_val    (dur_of(nxt)),
      .tick        (bus.tick),
      .expire      (expire),
      .cnt_o       (cnt)
   );

   // Lights are registered from the successor state so they change together
   // with state_q and never see an input combinationally.
   always_ff @(posedge clk) begin
      if (!sys_reset_n) begin
         state_q    <= MAIN_GRN;
         main_q     <= LT_GRN;
         side_q     <= LT_RED;
         walk_rst_q <= 1'b0;
      end else begin
         walk_rst_q <= 1'b0;
         if (expire) begin
            state_q    <= nxt;
            main_q     <= main_lights(nxt);
            side_q     <= side_lights(nxt);
            walk_rst_q <= (nxt == WALK);
         end
      end
   end

   assign bus.main_light         = main_q;
   assign bus.side_light         = side_q;
   assign bus.walkRegister_reset = walk_rst_q;
   assign bus.state_o            = state_q;

`ifdef TL_WALK_FLASH_EN
   assign bus.walk_lamp = (state_q == WALK) && ((cnt > CNT_W'(T_FLASH)) || cnt[0]);
`else
   logic cnt_unused;
   assign cnt_unused    = ^cnt;
   assign bus.walk_lamp = (state_q == WALK);
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised and directed bench for traffic_light_fsm against a tick-level
// behavioural model of the light sequence.
module tb_traffic_light_fsm;
   import tl_pkg::*;

   localparam int T_BASE  = 6;
   localparam int T_EXT   = 3;
   localparam int T_YEL   = 2;
   localparam int T_FLASH = 2;
   localparam int CNT_W   = 4;

   logic clk = 1'b0;
   logic sys_reset_n = 1'b0;

   traffic_light_fsm_if bus();

   traffic_light_fsm #(
      .T_BASE (T_BASE), .T_EXT (T_EXT), .T_YEL (T_YEL),
      .T_FLASH(T_FLASH), .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .sys_reset_n (sys_reset_n),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: phase + ticks remaining ----------------
   tl_state_e m_ph = MAIN_GRN;
   int        m_rem = T_BASE;
   bit        m_wr = 1'b0;
   bit        m_valid = 1'b0;

   function automatic int dur(tl_state_e p);
      if (p == MAIN_GRN || p == SIDE_GRN) return T_BASE;
      if (p == MAIN_YEL || p == SIDE_YEL) return T_YEL;
      return T_EXT;
   endfunction

   function automatic tl_state_e follow(tl_state_e p, bit sen, bit walk);
      case (p)
         MAIN_GRN: return sen ? MAIN_EXT : MAIN_YEL;
         MAIN_EXT: return MAIN_YEL;
         MAIN_YEL: return walk ? WALK : SIDE_GRN;
         WALK:     return SIDE_GRN;
         SIDE_GRN: return sen ? SIDE_EXT : SIDE_YEL;
         SIDE_EXT: return SIDE_YEL;
         default:  return MAIN_GRN;
      endcase
   endfunction

   function automatic logic [2:0] exp_main(tl_state_e p);
      if (p == MAIN_GRN || p == MAIN_EXT) return 3'b001;
      if (p == MAIN_YEL) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [2:0] exp_side(tl_state_e p);
      if (p == SIDE_GRN || p == SIDE_EXT) return 3'b001;
      if (p == SIDE_YEL) return 3'b010;
      return 3'b100;
   endfunction

   function automatic bit exp_walk(tl_state_e p, int rem);
      if (p != WALK) return 1'b0;
`ifdef TL_WALK_FLASH_EN
      return (rem > T_FLASH) || (rem % 2 == 1);
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk) begin
      if (!sys_reset_n) begin
         m_ph = MAIN_GRN; m_rem = T_BASE; m_wr = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
         m_wr = 1'b0;
         if (bus.tick) begin
            if (m_rem == 1) begin
               m_ph  = follow(m_ph, bus.sensor, bus.walkRegister_status);
               m_rem = dur(m_ph);
               m_wr  = (m_ph == WALK);
            end else begin
               m_rem--;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("main_light", bus.main_light, exp_main(m_ph));
         check("side_light", bus.side_light, exp_side(m_ph));
         check("walk_lamp", bus.walk_lamp, exp_walk(m_ph, m_rem));
         check("walk_reset", bus.walkRegister_reset, m_wr);
         check("state_o", bus.state_o, m_ph);
         check("cnt", dut.u_timer.cnt_q, m_rem);
         check("one_dir", (bus.main_light != 3'b100) && (bus.side_light != 3'b100), 0);
      end
   end

   // ---------------- stimulus ----------------
   int mode = 0;   // 0: tick always, 1: tick every 4th cycle, 2: random
   int cyc_n = 0;

   task automatic apply_mode();
      if (mode == 0) bus.tick = 1'b1;
      else if (mode == 1) bus.tick = (cyc_n % 4 == 0);
   endtask

   task automatic adv();
      bit pulse;
      pulse = bus.walkRegister_reset;
      @(posedge clk); #1;
      cyc_n++;
      if (mode == 2) begin
         if (pulse) bus.walkRegister_status = 1'b0;
         if ($urandom_range(0, 14) == 0) bus.walkRegister_status = 1'b1;
         bus.sensor  = $urandom_range(0, 1) != 0;
         bus.tick    = $urandom_range(0, 2) != 0;
         sys_reset_n = $urandom_range(0, 299) != 0;
      end else begin
         apply_mode();
      end
   endtask

   task automatic do_reset();
      sys_reset_n = 1'b0;
      @(posedge clk); #1;
      sys_reset_n = 1'b1;
      cyc_n = 0;
      apply_mode();
   endtask

   logic [2:0]       rm[0:31], rs[0:31], rst_s[0:31];
   logic             rw[0:31], rr[0:31];
   logic [CNT_W-1:0] rc[0:31];

   task automatic record(int n);
      for (int c = 0; c < n; c++) begin
         if (c > 0) adv();
         @(negedge clk);
         rm[c] = bus.main_light; rs[c] = bus.side_light; rst_s[c] = bus.state_o;
         rw[c] = bus.walk_lamp;  rr[c] = bus.walkRegister_reset;
         rc[c] = dut.u_timer.cnt_q;
      end
   endtask

   int n_main, n_side;

   initial begin
      bus.tick = 1'b1; bus.sensor = 1'b0; bus.walkRegister_status = 1'b0;

      // Basic cycle, tick held high, no sensor, no walk
      mode = 0;
      do_reset();
      record(17);
      check("s1_c0_main", rm[0], 3'b001);
      check("s1_c0_side", rs[0], 3'b100);
      check("s1_c0_walk", rw[0], 1'b0);
      check("s1_c0_wrst", rr[0], 1'b0);
      check("s1_c5_main", rm[5], 3'b001);
      check("s1_c6_main", rm[6], 3'b010);
      check("s1_c7_main", rm[7], 3'b010);
      check("s1_c8_main", rm[8], 3'b100);
      check("s1_c8_side", rs[8], 3'b001);
      check("s1_c13_side", rs[13], 3'b001);
      check("s1_c14_side", rs[14], 3'b010);
      check("s1_c15_side", rs[15], 3'b010);
      check("s1_c16_main", rm[16], 3'b001);
      check("s1_c16_state", rst_s[16], MAIN_GRN);

      // Sensor held: both greens extended to T_BASE+T_EXT
      bus.sensor = 1'b1;
      do_reset();
      record(22);
      n_main = 0; n_side = 0;
      for (int c = 0; c < 22; c++) begin
         if (rm[c] == 3'b001) n_main++;
         if (rs[c] == 3'b001) n_side++;
      end
      check("s2_main_green_cycles", n_main, 9);
      check("s2_side_green_cycles", n_side, 9);
      check("s2_c9_main", rm[9], 3'b010);
      bus.sensor = 1'b0;

      // Walk request during MAIN_GRN
      bus.walkRegister_status = 1'b1;
      do_reset();
      record(12);
      check("s3_c7_wrst", rr[7], 1'b0);
      check("s3_c8_state", rst_s[8], WALK);
      check("s3_c8_wrst", rr[8], 1'b1);
      check("s3_c9_wrst", rr[9], 1'b0);
      check("s3_c9_main", rm[9], 3'b100);
      check("s3_c9_side", rs[9], 3'b100);
      check("s3_c10_state", rst_s[10], WALK);
      check("s3_c11_state", rst_s[11], SIDE_GRN);
`ifdef TL_WALK_FLASH_EN
      check("s3_walk_lamp_seq", {rw[8], rw[9], rw[10]}, 3'b101);
`else
      check("s3_walk_lamp_seq", {rw[8], rw[9], rw[10]}, 3'b111);
`endif

      // Reset during the second WALK cycle
      do_reset();
      record(10);
      check("s5_c9_state", rst_s[9], WALK);
      sys_reset_n = 1'b0;
      @(posedge clk); #1;
      sys_reset_n = 1'b1;
      @(negedge clk);
      check("s5_state", bus.state_o, MAIN_GRN);
      check("s5_main", bus.main_light, 3'b001);
      check("s5_walk_lamp", bus.walk_lamp, 1'b0);
      check("s5_wrst", bus.walkRegister_reset, 1'b0);
      check("s5_cnt", dut.u_timer.cnt_q, 6);
      bus.walkRegister_status = 1'b0;

      // Sparse tick: one in four cycles
      mode = 1;
      do_reset();
      record(30);
      n_main = 0;
      while (n_main < 30 && rst_s[n_main] == MAIN_GRN) n_main++;
      check("s4_main_grn_cycles", n_main, 21);
      check("s4_c1_cnt", rc[1], 5);
      check("s4_c3_cnt", rc[3], 5);
      check("s4_c5_cnt", rc[5], 4);

      // Randomised run against the model
      mode = 2;
      do_reset();
      repeat (3000) begin
         adv();
         @(negedge clk);
      end
      sys_reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Main/side-street traffic light sequencer that sits directly downstream of the walk-request latch. It consumes the latched walk request and a side-street car sensor, and it sequences both sets of lights plus the pedestrian walk lamp through a timed Moore state machine. When it grants a walk phase, it returns a one-cycle clear pulse to the walk-request latch.

## Interface
Parameters:
- T_BASE, 6: base green duration, in ticks (main and side).
- T_EXT, 3: sensor extension duration and walk phase duration, in ticks.
- T_YEL, 2: yellow duration, in ticks.
- T_FLASH, 2: number of final walk ticks during which the walk lamp flashes (used only with TL_WALK_FLASH_EN).
- CNT_W, 4: interval counter width. Every duration parameter must lie in 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- sys_reset_n  in  1  reset, synchronous, active-low.
- tick  in  1  single-cycle timebase enable (nominally 1 Hz).
- walkRegister_status  in  1  latched pedestrian request.
- sensor  in  1  side-street car present, level.
- walkRegister_reset  out  1  one-cycle clear pulse to the walk latch.
- main_light  out  3  {red,yellow,green}, one-hot.
- side_light  out  3  {red,yellow,green}, one-hot.
- walk_lamp  out  1  pedestrian walk lamp.
- state_o  out  3  current state encoding, for debug.

## Operation
- States:
  - MAIN_GRN: main 001, side 100.
  - MAIN_EXT: main 001, side 100.
  - MAIN_YEL: main 010, side 100.
  - WALK: main 100, side 100, walk_lamp 1.
  - SIDE_GRN: main 100, side 001.
  - SIDE_EXT: main 100, side 001.
  - SIDE_YEL: main 100, side 010.
- Interval counter `cnt`:
  - Loaded with the new state's duration on every state entry.
  - On each cycle with tick=1: if cnt==1 the state expires and the FSM transitions at that edge; otherwise cnt decrements.
  - With tick=0, cnt holds.
- Durations: MAIN_GRN/SIDE_GRN T_BASE; MAIN_EXT/SIDE_EXT/WALK T_EXT; MAIN_YEL/SIDE_YEL T_YEL.
- Transitions on expiry:
  - MAIN_GRN → MAIN_EXT if sensor=1, else → MAIN_YEL.
  - MAIN_EXT → MAIN_YEL.
  - MAIN_YEL → WALK if walkRegister_status=1, else → SIDE_GRN.
  - WALK → SIDE_GRN.
  - SIDE_GRN → SIDE_EXT if sensor=1, else → SIDE_YEL.
  - SIDE_EXT → SIDE_YEL.
  - SIDE_YEL → MAIN_GRN.
- sensor and walkRegister_status are sampled only in the expiry cycle. Values at other times are ignored.
- walkRegister_reset is a registered output. It is high for exactly the first cycle of WALK, and low at all other times.
- Lights, walk_lamp and state_o are decoded from the state register only, with no input-to-output combinational path.

## Timing
- Reset (sys_reset_n=0 at an edge):
  - state MAIN_GRN, cnt=T_BASE.
  - main_light=001, side_light=100.
  - walk_lamp=0, walkRegister_reset=0.
- Reset takes priority over tick and transitions. Reset in mid-state, including mid-WALK, aborts immediately; the walk latch keeps its request.
- Light outputs change in the cycle after the expiry edge (Moore, zero added latency beyond the state register).
- With tick held at 1, each state lasts exactly its duration in cycles. A state entered between ticks lasts its duration in ticks plus a partial tick.
- A walk request arriving in the same cycle as MAIN_YEL expiry is honoured. A request arriving later waits for the next cycle.
- Never more than one direction is non-red at a time.

## Configuration
- TL_WALK_FLASH_EN defined:
  - In WALK, walk_lamp = 1 while cnt > T_FLASH.
  - Otherwise walk_lamp = cnt[0]; it toggles per tick.
- Undefined: walk_lamp is steady 1 throughout WALK and T_FLASH is unused.

## Structure
- Package tl_pkg holds:
  - the state enum (3-bit);
  - light encodings LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001;
  - the default duration constants.
- Sub-module tl_interval_timer:
  - Ports: load, load_val, tick, expire.
  - Owns the cnt register.
  - The FSM instantiates it once.

## Test plan
- Reset, tick=1 constant, sensor=0, walk=0 → cycle-accurate sequence:
  - MAIN_GRN 6 cycles;
  - MAIN_YEL 2 cycles;
  - SIDE_GRN 6 cycles;
  - SIDE_YEL 2 cycles;
  - MAIN_GRN again at cycle 16.
- sensor=1 constant → MAIN_GRN+MAIN_EXT 9 cycles green, SIDE_GRN+SIDE_EXT 9 cycles green.
- walkRegister_status=1 during MAIN_GRN → after MAIN_YEL:
  - WALK for 3 cycles, with main=side=100 and walk_lamp=1;
  - walkRegister_reset=1 for exactly the first WALK cycle;
  - then SIDE_GRN.
- tick pulsed every 4th cycle → MAIN_GRN lasts 6 ticks (21–24 cycles); cnt is unchanged on non-tick cycles.
- sys_reset_n low for 1 cycle in the second WALK cycle → next cycle MAIN_GRN, walk_lamp=0, walkRegister_reset=0, cnt=6.
- TL_WALK_FLASH_EN defined, T_EXT=3, T_FLASH=2, tick=1 → walk_lamp 1,0,1 over the three WALK cycles. Undefined → 1,1,1.
